// File: rtl/mux4_arbiter.sv
// rtl/mux4_arbiter.sv - round-robin arbiter driving a mux4 select, with hold-time preemption
// Two-state FSM; all outputs registered, grant latency one cycle from the sampled request.
module mux4_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic [7:0] hold_cnt
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("mux4_arbiter: HOLD_MAX out of range 2..255");
  end

  state_t     state;
  logic [1:0] ptr;
  logic [3:0] cand;
  logic [2:0] win;
  logic       win_found;
  logic [1:0] win_idx;
  logic       owner_req;
  logic       at_limit;
  logic       do_grant;

  // First candidate at or after p, wrapping mod 4; {found, index}.
  function automatic logic [2:0] pick(input logic [3:0] c, input logic [1:0] p);
    logic [2:0] r;
    logic [1:0] k;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      k = p + i[1:0];
      if (c[k]) r = {1'b1, k};
    end
    return r;
  endfunction

  // The current owner never competes against itself when rotating.
  always_comb begin
    cand = req;
    if (state == GRANT) cand[sel] = 1'b0;
  end

  assign win       = pick(cand, ptr);
  assign win_found = win[2];
  assign win_idx   = win[1:0];
  assign owner_req = req[sel];
  assign at_limit  = (hold_cnt >= HOLD_LAST);
  assign do_grant  = win_found && ((state == IDLE) || !owner_req || at_limit);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= 4'b0000;
      sel      <= 2'd0;
      busy     <= 1'b0;
      hold_cnt <= 8'd0;
      ptr      <= 2'd0;
    end else if (do_grant) begin
      state    <= GRANT;
      grant    <= 4'b0001 << win_idx;
      sel      <= win_idx;
      busy     <= 1'b1;
      hold_cnt <= 8'd0;
      ptr      <= win_idx + 2'd1;
    end else if (state == GRANT) begin
      if (owner_req) begin
        // Lone holder at the limit simply restarts its count.
        hold_cnt <= at_limit ? 8'd0 : hold_cnt + 8'd1;
      end else begin
        state    <= IDLE;
        grant    <= 4'b0000;
        busy     <= 1'b0;
        hold_cnt <= 8'd0;
      end
    end
  end

  a_grant_onehot : assert property (@(posedge clk) $onehot0(grant));
  a_busy_match   : assert property (@(posedge clk) busy == (grant != 4'b0000));
  a_sel_match    : assert property (@(posedge clk) !busy || grant[sel]);

endmodule
